// File: rtl/dongwon_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller in front of dongwon_ram.
// Latency: read hit -> rvalid 1 cycle after accept; read miss -> rvalid 3 cycles; write -> wack 2 cycles.
// Backpressure: one request in flight; cpu_ready is high only in IDLE, and cpu_req is ignored otherwise.
//
// Ports:
//   clk, reset                        single clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata CPU request (sampled while cpu_ready=1)
//   cpu_ready/cpu_rvalid/cpu_rdata    CPU handshake and read return
//   cpu_wack                          write-issued pulse
//   mem_run/mem_we/mem_addr/mem_wdata RAM command; mem_rdata is the RAM's registered read data
//   mem_state                         RAM state_of_cache code (IDLE=000 WRITE=010 MISS=100 HIT=101)
module dongwon_cache_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LINES      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_wack,
   output logic                  mem_run,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [2:0]            mem_state
);

   localparam int IDX = $clog2(LINES);
   localparam int TAG = ADDR_WIDTH - 2 - IDX;

   localparam logic [2:0] CODE_IDLE  = 3'b000;
   localparam logic [2:0] CODE_WRITE = 3'b010;
   localparam logic [2:0] CODE_MISS  = 3'b100;
   localparam logic [2:0] CODE_HIT   = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HIT,
      S_MISS_REQ,
      S_FILL,
      S_WRITE
   } state_t;

   state_t state;

   // Line store. Tags and data carry no reset; only the valid bits matter after reset.
   logic [LINES-1:0]      line_valid;
   logic [TAG-1:0]        line_tag  [LINES];
   logic [DATA_WIDTH-1:0] line_data [LINES];

   // Request captured at the accept edge.
   logic [IDX-1:0]        req_idx;
   logic [TAG-1:0]        req_tag;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  req_hit;

   // Lookup of the incoming address against the current line state.
   logic [IDX-1:0]        cpu_idx;
   logic [TAG-1:0]        cpu_tag;
   logic [ADDR_WIDTH-1:0] cpu_addr_al;
   logic                  lookup_hit;
   logic                  addr_lsb_unused;

   assign cpu_idx         = cpu_addr[2+IDX-1:2];
   assign cpu_tag         = cpu_addr[ADDR_WIDTH-1:2+IDX];
   assign cpu_addr_al     = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
   assign lookup_hit      = line_valid[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);
   assign addr_lsb_unused = ^cpu_addr[1:0];

   assign cpu_ready = (state == S_IDLE);

   // Control FSM. RAM command outputs are registered on the edge that enters
   // the state they belong to, so they are valid for the whole state cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         line_valid <= '0;
         cpu_rvalid <= 1'b0;
         cpu_wack   <= 1'b0;
         cpu_rdata  <= '0;
         mem_run    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_state  <= CODE_IDLE;
         req_idx    <= '0;
         req_tag    <= '0;
         req_wdata  <= '0;
         req_hit    <= 1'b0;
      end else begin
         cpu_rvalid <= 1'b0;
         cpu_wack   <= 1'b0;
         mem_run    <= 1'b0;
         mem_we     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cpu_req) begin
                  req_idx   <= cpu_idx;
                  req_tag   <= cpu_tag;
                  req_wdata <= cpu_wdata;
                  req_hit   <= lookup_hit;
                  if (cpu_we) begin
                     state     <= S_WRITE;
                     mem_run   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= cpu_addr_al;
                     mem_wdata <= cpu_wdata;
                     mem_state <= CODE_WRITE;
                  end else if (lookup_hit) begin
                     // Hit data is returned during the HIT cycle itself.
                     state      <= S_HIT;
                     cpu_rvalid <= 1'b1;
                     cpu_rdata  <= line_data[cpu_idx];
                     mem_state  <= CODE_HIT;
                  end else begin
                     state     <= S_MISS_REQ;
                     mem_run   <= 1'b1;
                     mem_addr  <= cpu_addr_al;
                     mem_state <= CODE_MISS;
                  end
               end
            end
            S_HIT: begin
               state     <= S_IDLE;
               mem_state <= CODE_IDLE;
            end
            S_MISS_REQ: begin
               // RAM latches out_data at the end of this cycle.
               state <= S_FILL;
            end
            S_FILL: begin
               state               <= S_IDLE;
               cpu_rdata           <= mem_rdata;
               cpu_rvalid          <= 1'b1;
               line_valid[req_idx] <= 1'b1;
               mem_state           <= CODE_IDLE;
            end
            S_WRITE: begin
               state     <= S_IDLE;
               cpu_wack  <= 1'b1;
               mem_state <= CODE_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               mem_state <= CODE_IDLE;
            end
         endcase
      end
   end

   // Line tag/data updates. Gated by reset so an aborted fill leaves no trace.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_FILL) begin
            line_data[req_idx] <= mem_rdata;
            line_tag[req_idx]  <= req_tag;
         end else if ((state == S_WRITE) && req_hit) begin
            line_data[req_idx] <= req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_dongwon_cache_ctrl.sv
module tb_dongwon_cache_ctrl;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int LINES = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ready;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_wack;
   logic          mem_run;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [2:0]    mem_state;

   always #5 clk = ~clk;

   dongwon_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINES(LINES)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_wack(cpu_wack),
      .mem_run(mem_run), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_state(mem_state)
   );

   // Byte-addressed RAM with registered read data (the environment).
   logic [7:0] ram [256];
   always @(posedge clk) begin
      if (mem_run && mem_we)
         for (int i = 0; i < 4; i++) ram[mem_addr + 8'(i)] = mem_wdata[8*i +: 8];
      if (mem_run && !mem_we)
         mem_rdata <= {ram[mem_addr + 8'd3], ram[mem_addr + 8'd2], ram[mem_addr + 8'd1], ram[mem_addr]};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event (t=%0t)", name, $time);
   endtask

   // Reference model: word memory plus a per-index record of which tag is resident.
   logic [31:0] ref_mem [64];
   bit          m_valid [LINES];
   int          m_tag   [LINES];

   typedef struct {
      bit          we;
      logic [7:0]  addr;
      logic [31:0] data;
      int          lat;
      int          runs;
      logic [2:0]  code;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   runs_seen = 0;
   bit   mon_en = 1'b0;
   int   prev_acc = -100;
   int   prev_rdy = 0;

   // Monitor: compares RAM commands and CPU responses against the queued expectations.
   always @(negedge clk) begin
      if (!reset && mon_en) begin
         if (sb.size() > 0 && cyc == sb[0].acc)
            chk("mem_state", {29'd0, mem_state}, {29'd0, sb[0].code});
         if (mem_run) begin
            if (sb.size() == 0) flag("spurious_mem_run");
            else begin
               chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
               chk("mem_addr", {24'd0, mem_addr}, {24'd0, sb[0].addr});
               if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].data);
               runs_seen++;
            end
         end
         if (cpu_rvalid || cpu_wack) begin
            if (sb.size() == 0) flag("spurious_response");
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("resp_is_wack", {31'd0, cpu_wack}, {31'd0, e.we});
               chk("resp_is_rvalid", {31'd0, cpu_rvalid}, {31'd0, !e.we});
               if (!e.we) chk("rdata", cpu_rdata, e.data);
               chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               chk("mem_run_count", 32'(runs_seen), 32'(e.runs));
               runs_seen = 0;
            end
         end
      end
   end

   task automatic issue(input bit we, input logic [7:0] a, input logic [31:0] d);
      exp_t       e;
      int         n;
      int         first_cyc;
      logic [7:0] wa;
      int         idx;
      int         tag;
      bit         hit;
      @(negedge clk);
      first_cyc = cyc;
      n = 0;
      while (!cpu_ready && n < 50) begin
         // Junk requests while busy must be ignored.
         cpu_req   = 1'($urandom_range(0, 1));
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = 8'($urandom);
         cpu_wdata = $urandom;
         @(negedge clk);
         n++;
      end
      if (!cpu_ready) begin
         flag("ready_timeout");
         cpu_req = 1'b0;
         return;
      end
      if (first_cyc == prev_acc) chk("ready_gap", 32'(cyc - prev_acc), 32'(prev_rdy));
      wa  = a & 8'hFC;
      idx = (int'(wa) / 4) % LINES;
      tag = int'(wa) / (4 * LINES);
      hit = m_valid[idx] && (m_tag[idx] == tag);
      e.we   = we;
      e.addr = wa;
      if (we) begin
         e.data = d; e.lat = 2; e.runs = 1; e.code = 3'b010; prev_rdy = 1;
         ref_mem[int'(wa) / 4] = d;
      end else begin
         e.data = ref_mem[int'(wa) / 4];
         if (hit) begin e.lat = 1; e.runs = 0; e.code = 3'b101; prev_rdy = 1; end
         else     begin e.lat = 3; e.runs = 1; e.code = 3'b100; prev_rdy = 2; end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
      end
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      @(posedge clk);
      #1;
      e.acc    = cyc;
      prev_acc = cyc;
      sb.push_back(e);
      cpu_req   = 1'b0;
      cpu_addr  = 8'($urandom);
      cpu_wdata = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         flag("drain_timeout");
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_state();
      chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("rst_cpu_wack", {31'd0, cpu_wack}, 32'd0);
      chk("rst_mem_run", {31'd0, mem_run}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_state", {29'd0, mem_state}, 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
      end
      sb.delete();
      runs_seen = 0;
      prev_acc  = -100;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int          n;
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         w = (i == 4) ? 32'hDEADBEEF : $urandom;
         ref_mem[i] = w;
         for (int b = 0; b < 4; b++) ram[4*i + b] = w[8*b +: 8];
      end
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state();
      reset = 1'b0;
      mon_en = 1'b1;

      // Cold miss, then hit, on 0x10.
      issue(1'b0, 8'h10, 32'h0);
      issue(1'b0, 8'h10, 32'h0);
      // Write-through hit; RAM bytes land little-endian.
      issue(1'b1, 8'h10, 32'h12345678);
      drain();
      chk("ram_10", {24'd0, ram[8'h10]}, 32'h78);
      chk("ram_11", {24'd0, ram[8'h11]}, 32'h56);
      chk("ram_12", {24'd0, ram[8'h12]}, 32'h34);
      chk("ram_13", {24'd0, ram[8'h13]}, 32'h12);
      issue(1'b0, 8'h13, 32'h0);   // low address bits ignored
      // Write miss without allocation.
      issue(1'b1, 8'h20, 32'hA5A5A5A5);
      issue(1'b0, 8'h20, 32'h0);
      // Conflict eviction on index 1.
      issue(1'b0, 8'h04, 32'h0);
      issue(1'b0, 8'h44, 32'h0);
      issue(1'b0, 8'h04, 32'h0);
      drain();

      // Reset during FILL aborts the miss.
      mon_en = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
      @(posedge clk); #1;          // accept
      cpu_req = 1'b0;
      @(posedge clk); #1;          // now in FILL
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_state();
      reset = 1'b0;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (cpu_rvalid) n++;
      end
      chk("abort_no_rvalid", 32'(n), 32'd0);
      model_reset();
      mon_en = 1'b1;
      issue(1'b0, 8'h30, 32'h0);
      issue(1'b0, 8'h30, 32'h0);

      // Randomized traffic over a small address pool with occasional wide addresses.
      for (int k = 0; k < 300; k++) begin
         logic [7:0] a;
         bit         we;
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                          : 8'($urandom_range(0, 23) * 4 + $urandom_range(0, 3));
         we = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue(we, a, $urandom);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dongwon_cache_ctrl.md
# dongwon_cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller that acts as the initiator toward `dongwon_ram`. It accepts one 32-bit word request at a time from the CPU side and issues `run`/`we`/`addr`/`in_data` plus a `state_of_cache` code to the RAM. It consumes the RAM's registered `out_data` on read misses. The block sits between the core load/store unit and the byte-addressed RAM, and serves read hits locally from its own line store.

## Interface
- `ADDR_WIDTH`, default 8: byte address width on both sides.
- `DATA_WIDTH`, default 32: word width; fixed at 32 because the RAM packs 4 bytes per access.
- `LINES`, default 16: number of one-word cache lines; must be a power of 2. `IDX = log2(LINES)`, `TAG = ADDR_WIDTH-2-IDX`, with `TAG >= 1`.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: **synchronous, active-high** reset.
- `cpu_req` in 1: request strobe; sampled only while `cpu_ready`=1.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_WIDTH: byte address; bits [1:0] are ignored (word aligned).
- `cpu_wdata` in DATA_WIDTH: write data.
- `cpu_ready` out 1: high exactly when the FSM is in IDLE.
- `cpu_rvalid` out 1: one-cycle pulse when `cpu_rdata` is valid.
- `cpu_rdata` out DATA_WIDTH: read data; holds its value until the next `cpu_rvalid`.
- `cpu_wack` out 1: one-cycle pulse when a write has been issued to the RAM.
- `mem_run` out 1: drives RAM `run`.
- `mem_we` out 1: drives RAM `we`.
- `mem_addr` out ADDR_WIDTH: drives RAM `addr`; bits [1:0] are always 0.
- `mem_wdata` out DATA_WIDTH: drives RAM `in_data`.
- `mem_rdata` in DATA_WIDTH: from RAM `out_data`; valid the cycle after a `run`/`!we` cycle.
- `mem_state` out 3: drives RAM `state_of_cache`. Codes: IDLE=000, WRITE=010, READ_MISS=100, READ_HIT=101.

## Operation
- Storage per line: `valid` (1), `tag` (TAG), `data` (32). Index = `cpu_addr[2+IDX-1:2]`. Tag = `cpu_addr[ADDR_WIDTH-1:2+IDX]`.
- Request capture: on the edge where IDLE and `cpu_req`=1, latch `addr` (with [1:0] forced to 0), `we`, and `wdata`. Compute hit = `valid[idx]` && tag match, using the line state at that edge.
- FSM states: IDLE, HIT, MISS_REQ, FILL, WRITE.
  - IDLE → HIT: read request that hits.
  - IDLE → MISS_REQ: read request that misses.
  - IDLE → WRITE: any write request.
  - No request: stay in IDLE.
  - HIT → IDLE: register `cpu_rdata`=`data[idx]` and pulse `cpu_rvalid`.
  - MISS_REQ → FILL: `mem_run`=1, `mem_we`=0, `mem_addr`=latched address.
  - FILL → IDLE: capture `mem_rdata`; write it to `data[idx]`, set `tag[idx]`, set `valid[idx]`=1; register `cpu_rdata`; pulse `cpu_rvalid`.
  - WRITE → IDLE: `mem_run`=1, `mem_we`=1, `mem_wdata`=latched data. If the line hits, update `data[idx]` in the same cycle. If it misses, leave the line untouched (no allocate). Pulse `cpu_wack`.
- `mem_state` per state: 000 in IDLE, 101 in HIT, 100 in MISS_REQ and FILL, 010 in WRITE.
- `mem_run`/`mem_we` are 0 in every state not listed above. `mem_addr` and `mem_wdata` hold their last value when `mem_run`=0.
- A conflict miss overwrites the line unconditionally. No dirty state exists, because every write goes through to the RAM.
- `cpu_req` while `cpu_ready`=0 is ignored and not queued.

## Timing
- Reset (sampled high at an edge):
  - FSM → IDLE.
  - All `valid` bits → 0.
  - `cpu_rvalid`, `cpu_wack`, `mem_run`, `mem_we` → 0.
  - `cpu_rdata`, `mem_addr`, `mem_wdata` → 0.
  - `mem_state` → 000.
  - `cpu_ready` → 1 while reset is held.
- Reset mid-operation aborts the request: no `cpu_rvalid`/`cpu_wack` for it, and `mem_run` is low from the next cycle. Reset has priority over every other event.
- Latencies, counted from the accept edge N (request in cycle N-1, accepted at edge N):
  - Read hit: `cpu_rvalid` high in cycle N+1; `cpu_ready` high again in cycle N+2.
  - Read miss: `mem_run` high in cycle N+1; RAM latches `out_data` at edge N+2; FILL runs in cycle N+2; `cpu_rvalid` high in cycle N+3; `cpu_ready` high in N+3.
  - Write: `mem_run`/`mem_we` high in cycle N+1; `cpu_wack` high in cycle N+2; `cpu_ready` high in N+2.
- Back-to-back requests: the next request can be accepted at the first edge where `cpu_ready`=1. A read of an address written immediately before returns the written data, whether it hits or misses.
- The address wraps naturally at ADDR_WIDTH. The controller performs no bounds check on `addr+3`.

## Test plan
1. Cold read miss: after reset, RAM word at 0x10 = 0xDEADBEEF; read 0x10 → `mem_run`/`!mem_we`/`mem_state`=100 for one cycle, `cpu_rvalid` with 0xDEADBEEF 3 cycles after accept.
2. Read hit: repeat the read of 0x10 → no `mem_run`, `mem_state`=101, `cpu_rvalid` with 0xDEADBEEF 1 cycle after accept.
3. Write-through hit: write 0x12345678 to 0x10 → RAM bytes 0x10..0x13 = 78,56,34,12 and `cpu_wack` pulses; the next read of 0x10 hits and returns 0x12345678.
4. Write miss, no allocate: write 0xA5A5A5A5 to 0x20 with line empty → RAM updated; the next read of 0x20 misses (`mem_state`=100) and returns 0xA5A5A5A5.
5. Conflict eviction (LINES=16): read 0x04, then 0x44 (same index), then 0x04 → all three are misses; returned data matches RAM.
6. Reset mid-miss: assert `reset` in the FILL cycle → no `cpu_rvalid`, `mem_run`=0, `cpu_ready`=1; the next read of the same address misses.
